rs_msg_gen: RTL and testbench

Parametrised Reed-Solomon message source for the RS encoder path. Emits framed message symbols (K data symbols followed by N−K parity slots) over a valid/ready handshake, with four selectable payload modes, start/end-of-frame markers and a frame counter. It replaces the free-running 8-bit incrementing stimulus in RS encoder benches, and is synthesizable so it can also act as an on-chip BIST source.

---
 rtl/rs_gen_pkg.sv | 28 ++
 rtl/rs_prbs16.sv | 32 +++
 rtl/rs_msg_gen.sv | 179 +++++++++++++++++
 tb/tb_rs_msg_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gen_pkg.sv
// rtl/rs_gen_pkg.sv - shared encodings and constants for the RS message source
//
// Purpose: payload mode encodings, FSM state constants, LFSR taps and default
// seed, plus the single-step LFSR function used by rs_prbs16.
package rs_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_IDX   = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DATA   = 2'd1;
  localparam state_t ST_PARITY = 2'd2;

  // x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10
  localparam logic [15:0] PRBS_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [15:0] prbs_next(input logic [15:0] s);
    return {s[14:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/rs_prbs16.sv
// rtl/rs_prbs16.sv - 16-bit Fibonacci LFSR with seed load and advance
//
// Ports:
//   clk, rst     clock, synchronous active-low reset (loads seed)
//   load         reload state from seed
//   advance      take one LFSR step
//   seed         value loaded on reset or load
//   state        current LFSR state
//   state_next   state after one step (combinational look-ahead)
module rs_prbs16
  import rs_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] seed,
  output logic [15:0] state,
  output logic [15:0] state_next
);

  assign state_next = prbs_next(state);

  always_ff @(posedge clk) begin
    if (!rst || load) begin
      state <= seed;
    end else if (advance) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/rs_msg_gen.sv
// rtl/rs_msg_gen.sv - framed Reed-Solomon message symbol source
//
// Emits K data symbols then N-K parity slots per frame over valid/ready.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   en           run enable, sampled in IDLE and at the end of each frame
//   mode         payload: 0 free count, 1 frame index, 2 PRBS, 3 constant
//   const_val    payload for mode 3
//   m_ready      downstream ready
//   m_valid      m_data carries a message symbol
//   m_data       message symbol
//   m_sof/m_eof  first / K-th data symbol of the frame
//   parity_slot  high during the N-K parity slots
//   frame_cnt    completed frames, wrapping
module rs_msg_gen
  import rs_gen_pkg::*;
#(
  parameter int          SYM_W = 8,
  parameter int          N     = 255,
  parameter int          K     = 239,
  parameter logic [15:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SYM_W-1:0] const_val,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [SYM_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eof,
  output logic             parity_slot,
  output logic [15:0]      frame_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_DATA = IW'(K - 1);
  localparam logic [IW-1:0] LAST_SLOT = IW'(N - K - 1);

  generate
    if (SYM_W < 3 || SYM_W > 16) begin : g_bad_sym_w
      $error("rs_msg_gen: SYM_W must be within 3..16");
    end
    if (K <= 0 || K >= N) begin : g_bad_k
      $error("rs_msg_gen: K must satisfy 0 < K < N");
    end
    if (N > (1 << SYM_W) - 1) begin : g_bad_n
      $error("rs_msg_gen: N must not exceed 2^SYM_W - 1");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
      $error("rs_msg_gen: SEED must be nonzero");
    end
  endgenerate

  state_t           state;
  mode_e            mode_l;
  logic [SYM_W-1:0] const_l;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    slot;
  logic [SYM_W-1:0] gcnt;
  logic [15:0]      prbs;
  logic [15:0]      prbs_nxt;
  logic             accept;
  logic             par_done;
  logic             start;

  rs_prbs16 u_prbs (
    .clk        (clk),
    .rst        (rst),
    .load       (1'b0),
    .advance    (accept),
    .seed       (SEED),
    .state      (prbs),
    .state_next (prbs_nxt)
  );

  // Symbol value for a given index; the caller supplies counter and LFSR
  // values already matching that symbol so m_data can be registered.
  function automatic logic [SYM_W-1:0] payload(
    input mode_e            md,
    input logic [IW-1:0]    i,
    input logic [SYM_W-1:0] c,
    input logic [15:0]      p,
    input logic [SYM_W-1:0] k
  );
    case (md)
      MODE_CNT:  return c;
      MODE_IDX:  return SYM_W'(i);
      MODE_PRBS: return p[SYM_W-1:0];
      default:   return k;
    endcase
  endfunction

  always_comb begin
    accept   = 1'b0;
    par_done = 1'b0;
    start    = 1'b0;
    accept   = (state == ST_DATA) && m_valid && m_ready;
    par_done = (state == ST_PARITY) && m_ready && (slot == LAST_SLOT);
    // A new frame may follow the last parity slot directly, with no bubble
    start    = en && ((state == ST_IDLE) || par_done);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      mode_l      <= MODE_CNT;
      const_l     <= '0;
      idx         <= '0;
      slot        <= '0;
      gcnt        <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sof       <= 1'b0;
      m_eof       <= 1'b0;
      parity_slot <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // Counter and LFSR advance on every accepted symbol and survive IDLE
      if (accept) begin
        gcnt <= gcnt + 1'b1;
      end
      if (par_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (start) begin
        state       <= ST_DATA;
        mode_l      <= mode_e'(mode);
        const_l     <= const_val;
        idx         <= '0;
        m_valid     <= 1'b1;
        m_sof       <= 1'b1;
        m_eof       <= (LAST_DATA == '0);
        parity_slot <= 1'b0;
        m_data      <= payload(mode_e'(mode), '0, gcnt, prbs, const_val);
      end else begin
        case (state)
          ST_IDLE: begin
          end
          ST_DATA: begin
            if (accept) begin
              if (idx == LAST_DATA) begin
                state       <= ST_PARITY;
                idx         <= '0;
                slot        <= '0;
                m_valid     <= 1'b0;
                m_data      <= '0;
                m_sof       <= 1'b0;
                m_eof       <= 1'b0;
                parity_slot <= 1'b1;
              end else begin
                idx    <= idx + 1'b1;
                m_data <= payload(mode_l, idx + 1'b1, gcnt + 1'b1, prbs_nxt, const_l);
                m_sof  <= 1'b0;
                m_eof  <= ((idx + 1'b1) == LAST_DATA);
              end
            end
          end
          ST_PARITY: begin
            if (m_ready) begin
              if (slot == LAST_SLOT) begin
                state       <= ST_IDLE;
                parity_slot <= 1'b0;
              end else begin
                slot <= slot + 1'b1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_msg_gen.sv
// tb/tb_rs_msg_gen.sv - scoreboard bench for rs_msg_gen in two configurations
module tb_rs_msg_gen;

  localparam int SW_A = 8;
  localparam int N_A  = 255;
  localparam int K_A  = 239;
  localparam int SW_B = 4;
  localparam int N_B  = 15;
  localparam int K_B  = 11;
  localparam int TMO  = 6000;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
  } sym_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done_b = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit enters at bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int SW   = (g == 0) ? SW_A : SW_B;
    localparam int NN   = (g == 0) ? N_A : N_B;
    localparam int KK   = (g == 0) ? K_A : K_B;
    localparam int MASK = (1 << SW) - 1;

    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [SW-1:0] const_val;
    logic          m_ready;
    logic          m_valid;
    logic [SW-1:0] m_data;
    logic          m_sof;
    logic          m_eof;
    logic          parity_slot;
    logic [15:0]   frame_cnt;

    rs_msg_gen #(.SYM_W(SW), .N(NN), .K(KK), .SEED(16'hACE1)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .const_val   (const_val),
      .m_ready     (m_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_sof       (m_sof),
      .m_eof       (m_eof),
      .parity_slot (parity_slot),
      .frame_cnt   (frame_cnt)
    );

    // Frame-level model: at each frame start the whole frame is pushed
    sym_t          q[$];
    int            phase  = 0;   // 0 between frames, 1 data, 2 parity
    int            slots  = 0;
    int            acc    = 0;
    int            starts = 0;
    int            cnt    = 0;
    logic [15:0]   frames = 16'd0;
    logic [15:0]   lfsr   = 16'hACE1;
    logic          p_rst  = 1'b0;
    logic          p_en   = 1'b0;
    logic [1:0]    p_mode = 2'd0;
    logic [SW-1:0] p_const = '0;

    // Inputs change just after posedge, so values seen here are the ones the
    // next edge samples; p_* hold what the edge just passed sampled.
    always @(negedge clk) begin
      sym_t s;
      if (!p_rst) begin
        chk($sformatf("cfg%0d reset outputs", g),
            {m_valid, m_sof, m_eof, parity_slot, frame_cnt, 16'(m_data)}, '0);
        q.delete();
        phase  = 0;
        slots  = 0;
        acc    = 0;
        cnt    = 0;
        frames = 16'd0;
        lfsr   = 16'hACE1;
      end else begin
        if (phase == 0) begin
          chk($sformatf("cfg%0d frame_cnt", g), frame_cnt, frames);
          chk($sformatf("cfg%0d valid vs en", g), m_valid, p_en);
          if (p_en) begin
            for (int i = 0; i < KK; i++) begin
              case (p_mode)
                2'd0:    s.data = 16'(cnt);
                2'd1:    s.data = 16'(i);
                2'd2:    s.data = lfsr & 16'(MASK);
                default: s.data = 16'(p_const);
              endcase
              s.sof = (i == 0);
              s.eof = (i == KK - 1);
              q.push_back(s);
              cnt  = (cnt + 1) & MASK;
              lfsr = lfsr_step(lfsr);
            end
            phase = 1;
            acc   = 0;
            starts++;
          end else begin
            chk($sformatf("cfg%0d idle outputs", g),
                {m_sof, m_eof, parity_slot, 16'(m_data)}, '0);
          end
        end
        if (phase == 1) begin
          chk($sformatf("cfg%0d data phase flags", g), {m_valid, parity_slot}, 2'b10);
          if (q.size() > 0) begin
            chk($sformatf("cfg%0d symbol f%0d i%0d", g, starts, acc),
                {16'(m_data), m_sof, m_eof}, q[0]);
            if (m_ready) begin
              void'(q.pop_front());
              acc++;
              if (q.size() == 0) begin
                phase = 2;
                slots = 0;
              end
            end
          end
        end else if (phase == 2) begin
          chk($sformatf("cfg%0d parity phase flags", g), {m_valid, parity_slot}, 2'b01);
          if (m_ready) begin
            slots++;
            if (slots == NN - KK) begin
              phase = 0;
              frames++;
            end
          end
        end
      end
      p_rst   = rst;
      p_en    = en;
      p_mode  = mode;
      p_const = const_val;
    end
  end

  task automatic wait_starts(input string what, input int val);
    int c;
    c = 0;
    while (c < TMO && cfg[0].starts < val) begin
      cyc(1);
      c++;
    end
    chk({"timeout ", what}, 64'(c < TMO), 64'd1);
  endtask

  task automatic wait_acc(input string what, input int val);
    int c;
    c = 0;
    while (c < TMO && !(cfg[0].phase == 1 && cfg[0].acc >= val)) begin
      cyc(1);
      c++;
    end
    chk({"timeout ", what}, 64'(c < TMO), 64'd1);
  endtask

  // Small configuration: index payload, two back-to-back frames
  initial begin
    int c;
    cfg[1].rst       = 1'b0;
    cfg[1].en        = 1'b0;
    cfg[1].mode      = 2'd1;
    cfg[1].const_val = '0;
    cfg[1].m_ready   = 1'b1;
    cyc(3);
    cfg[1].rst = 1'b1;
    cyc(1);
    cfg[1].en = 1'b1;
    c = 0;
    while (c < 500 && cfg[1].starts < 2) begin
      cyc(1);
      c++;
    end
    chk("timeout small second frame", 64'(c < 500), 64'd1);
    cfg[1].en = 1'b0;
    cyc(40);
    chk("small frame_cnt after two frames", cfg[1].frame_cnt, 16'd2);
    chk("small idle after two frames", cfg[1].m_valid, 1'b0);
    done_b = 1'b1;
  end

  // Default configuration: all modes, backpressure, en drop, mid-frame reset
  initial begin
    int c;
    cfg[0].rst       = 1'b0;
    cfg[0].en        = 1'b0;
    cfg[0].mode      = 2'd0;
    cfg[0].const_val = '0;
    cfg[0].m_ready   = 1'b1;
    cyc(3);
    cfg[0].rst = 1'b1;
    cyc(2);

    cfg[0].en = 1'b1;
    cyc(N_A);
    chk("frame_cnt before N+1 edges", cfg[0].frame_cnt, 16'd0);
    cyc(1);
    chk("frame_cnt after N+1 edges", cfg[0].frame_cnt, 16'd1);

    cfg[0].mode = 2'd2;
    wait_starts("prbs frame", 3);
    cfg[0].mode      = 2'd3;
    cfg[0].const_val = 8'h5A;
    wait_starts("const frame", 4);
    wait_acc("const idx 100", 100);
    cfg[0].mode = 2'd0;
    wait_starts("count frame after const", 5);

    c = 0;
    while (c < TMO && cfg[0].starts < 7) begin
      cfg[0].m_ready = 1'($urandom_range(0, 1));
      cyc(1);
      c++;
    end
    chk("timeout backpressure frames", 64'(c < TMO), 64'd1);
    cfg[0].m_ready = 1'b1;

    wait_acc("en drop idx 5", 5);
    cfg[0].en = 1'b0;
    cyc(N_A + 10);
    chk("idle after en drop", cfg[0].m_valid, 1'b0);
    chk("frame_cnt after en drop", cfg[0].frame_cnt, 16'd7);

    cfg[0].en = 1'b1;
    wait_starts("frame before reset", 8);
    wait_acc("reset idx 50", 50);
    cfg[0].rst = 1'b0;
    cyc(2);
    cfg[0].rst = 1'b1;
    wait_starts("frame after reset", 9);
    cfg[0].en = 1'b0;
    cyc(N_A + 10);
    chk("frame_cnt after reset frame", cfg[0].frame_cnt, 16'd1);

    c = 0;
    while (c < 2000 && !done_b) begin
      cyc(1);
      c++;
    end
    chk("timeout small configuration", 64'(done_b), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
